// File: rtl/pkt_depacketizer_axis.sv
// rtl/pkt_depacketizer_axis.sv - PSK symbol depacketizer: header check, MSB-first bit packer, FWFT output FIFO
module pkt_depacketizer_axis #(
  parameter int          BYTES     = 1,
  parameter int          FIFO_AW   = 4,
  parameter logic [7:0]  SIGNATURE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sym_valid,
  input  logic               in_BPSK,
  input  logic [1:0]         in_QPSK,
  input  logic               BD_flag,
  input  logic               BD_sgn,
  output logic [8*BYTES-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser,
  output logic               is_bpsk,
  output logic               hdr_err,
  output logic               ovf,
  output logic               pkt_done
);
  localparam int BITS  = 8 * BYTES;
  localparam int FW    = $clog2(BITS + 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_DROP} state_t;

  state_t            state_q, state_d;
  logic              sgn_q, sgn_d;
  logic [30:0]       hdr_sr_q, hdr_sr_d;
  logic [4:0]        hdr_cnt_q, hdr_cnt_d;
  logic [15:0]       sym_rem_q, sym_rem_d;
  logic [15:0]       bits_rem_q, bits_rem_d;
  logic              bpsk_q, bpsk_d;
  logic              is_bpsk_q, is_bpsk_d;
  logic [BITS-1:0]   word_q, word_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              pend_q, pend_d;
  logic [BITS-1:0]   pend_data_q, pend_data_d;
  logic              pend_last_q, pend_last_d;
  logic              hdr_err_q, hdr_err_d;
  logic              pkt_done_q, pkt_done_d;
  logic              ovf_q, ovf_d;
  logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
  logic [BITS+1:0]   mem_q [DEPTH];

  logic [31:0]       hdr_full;
  logic [7:0]        hdr_mcs, hdr_sig;
  logic [15:0]       hdr_len, hdr_nsym;
  logic [16:0]       len_p1;
  logic              mcs_ok, mcs_bpsk;
  logic              bit_a, bit_b, two_bits;
  logic [BITS-1:0]   pk_w, data_a, data_b;
  logic [FW-1:0]     pk_f;
  logic              push_a, push_b, last_a, last_b;
  logic              fifo_empty, fifo_full, pop, wr_en, push_ok;
  logic [BITS+1:0]   wr_word, rd_word;

  assign hdr_full = {hdr_sr_q, in_BPSK ^ sgn_q};
  assign hdr_mcs  = hdr_full[31:24];
  assign hdr_len  = hdr_full[23:8];
  assign hdr_sig  = hdr_full[7:0];
  assign mcs_bpsk = (hdr_mcs == 8'h01);
  assign mcs_ok   = mcs_bpsk || (hdr_mcs == 8'h02);
  assign len_p1   = {1'b0, hdr_len} + 17'd1;
  assign hdr_nsym = mcs_bpsk ? hdr_len : len_p1[16:1];

  assign bit_a    = (bpsk_q ? in_BPSK : in_QPSK[1]) ^ sgn_q;
  assign bit_b    = in_QPSK[0] ^ sgn_q;
  assign two_bits = !bpsk_q && (bits_rem_q != 16'd1);

  // Up to two bits per symbol; a word closes when full or on the packet's last bit.
  always_comb begin
    pk_w   = word_q;
    pk_f   = fill_q;
    push_a = 1'b0;
    push_b = 1'b0;
    last_a = 1'b0;
    last_b = 1'b0;
    data_a = '0;
    data_b = '0;
    if (state_q == S_PLD && sym_valid) begin
      pk_w   = {pk_w[BITS-2:0], bit_a};
      pk_f   = pk_f + 1'b1;
      last_a = (bits_rem_q == 16'd1);
      if (pk_f == FW'(BITS) || last_a) begin
        push_a = 1'b1;
        data_a = pk_w << (FW'(BITS) - pk_f);
        pk_w   = '0;
        pk_f   = '0;
      end
      if (two_bits) begin
        pk_w   = {pk_w[BITS-2:0], bit_b};
        pk_f   = pk_f + 1'b1;
        last_b = (bits_rem_q == 16'd2);
        if (pk_f == FW'(BITS) || last_b) begin
          push_b = 1'b1;
          data_b = pk_w << (FW'(BITS) - pk_f);
          pk_w   = '0;
          pk_f   = '0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sgn_d      = sgn_q;
    hdr_sr_d   = hdr_sr_q;
    hdr_cnt_d  = hdr_cnt_q;
    sym_rem_d  = sym_rem_q;
    bits_rem_d = bits_rem_q;
    bpsk_d     = bpsk_q;
    word_d     = word_q;
    fill_d     = fill_q;
    hdr_err_d  = 1'b0;
    pkt_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (BD_flag) begin
          sgn_d     = BD_sgn;
          hdr_cnt_d = '0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (sym_valid) begin
          hdr_sr_d  = hdr_full[30:0];
          hdr_cnt_d = hdr_cnt_q + 5'd1;
          if (hdr_cnt_q == 5'd31) begin
            sym_rem_d  = hdr_nsym;
            bits_rem_d = hdr_len;
            if (!mcs_ok) begin
              hdr_err_d = 1'b1;
              state_d   = S_IDLE;
            end else if (hdr_sig != SIGNATURE) begin
              hdr_err_d = 1'b1;
              state_d   = (hdr_nsym == 16'd0) ? S_IDLE : S_DROP;
            end else if (hdr_len == 16'd0) begin
              pkt_done_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              bpsk_d  = mcs_bpsk;
              state_d = S_PLD;
            end
          end
        end
      end
      S_PLD: begin
        if (sym_valid) begin
          word_d     = pk_w;
          fill_d     = pk_f;
          bits_rem_d = bits_rem_q - (two_bits ? 16'd2 : 16'd1);
          if (last_a || last_b) begin
            pkt_done_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (sym_valid) begin
          sym_rem_d = sym_rem_q - 16'd1;
          if (sym_rem_q == 16'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    is_bpsk_d = !(state_d == S_PLD && !bpsk_d);
  end

  // Two words can close on one final QPSK symbol (odd BITS); the second waits one cycle.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = !fifo_empty && m_axis_tready;

  always_comb begin
    pend_d      = push_a && push_b;
    pend_data_d = data_b;
    pend_last_d = last_b;
    wr_en       = pend_q || push_a || push_b;
    if (pend_q)      wr_word = {pend_last_q, bpsk_q, pend_data_q};
    else if (push_a) wr_word = {last_a, bpsk_q, data_a};
    else             wr_word = {last_b, bpsk_q, data_b};
    push_ok  = wr_en && (!fifo_full || pop);
    ovf_d    = wr_en && fifo_full && !pop;
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sgn_q       <= 1'b0;
      hdr_sr_q    <= '0;
      hdr_cnt_q   <= '0;
      sym_rem_q   <= '0;
      bits_rem_q  <= '0;
      bpsk_q      <= 1'b0;
      is_bpsk_q   <= 1'b1;
      word_q      <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      sgn_q       <= sgn_d;
      hdr_sr_q    <= hdr_sr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      sym_rem_q   <= sym_rem_d;
      bits_rem_q  <= bits_rem_d;
      bpsk_q      <= bpsk_d;
      is_bpsk_q   <= is_bpsk_d;
      word_q      <= word_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
      hdr_err_q   <= hdr_err_d;
      pkt_done_q  <= pkt_done_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
  end

  assign rd_word       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? rd_word[BITS-1:0] : '0;
  assign m_axis_tuser  = m_axis_tvalid && rd_word[BITS];
  assign m_axis_tlast  = m_axis_tvalid && rd_word[BITS+1];
  assign is_bpsk       = is_bpsk_q;
  assign hdr_err       = hdr_err_q;
  assign pkt_done      = pkt_done_q;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_pkt_depacketizer_axis.sv
// tb/tb_pkt_depacketizer_axis.sv - randomized self-checking bench for pkt_depacketizer_axis
module tb_pkt_depacketizer_axis;
  localparam logic [7:0] SIG = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic       in_BPSK = 1'b0;
  logic [1:0] in_QPSK = 2'b00;
  logic       BD_flag = 1'b0;
  logic       BD_sgn = 1'b0;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       is_bpsk, hdr_err, ovf, pkt_done;

  pkt_depacketizer_axis #(.BYTES(1), .FIFO_AW(2), .SIGNATURE(SIG)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .in_BPSK(in_BPSK), .in_QPSK(in_QPSK),
    .BD_flag(BD_flag), .BD_sgn(BD_sgn), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .is_bpsk(is_bpsk), .hdr_err(hdr_err), .ovf(ovf), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         n_hdr_err = 0;
  int         n_pkt_done = 0;
  int         n_ovf = 0;
  int         ready_mode = 1;
  bit         noise = 1'b0;
  bit         mode_chk = 1'b0;
  logic       exp_mode = 1'b1;
  int         mode_bad = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  bit         pl[$];
  bit         stall_prev = 1'b0;
  logic [9:0] stall_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_err)  n_hdr_err++;
      if (pkt_done) n_pkt_done++;
      if (ovf)      n_ovf++;
      if (stall_prev)
        check("stable", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}), 32'({1'b1, stall_word}));
      if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_axis_tready = 1'b0;
      1: m_axis_tready = 1'b1;
      default: m_axis_tready = !m_axis_tready || (($urandom % 3) != 0);
    endcase
  endtask

  task automatic send_sym(input logic b, input logic [1:0] q);
    int gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      sym_valid = 1'b0;
      in_BPSK   = 1'($urandom);
      in_QPSK   = 2'($urandom);
      BD_flag   = noise && (($urandom % 6) == 0);
      BD_sgn    = 1'($urandom);
      tick();
    end
    sym_valid = 1'b1;
    in_BPSK   = b;
    in_QPSK   = q;
    BD_flag   = noise && (($urandom % 6) == 0);
    BD_sgn    = 1'($urandom);
    @(negedge clk);
    if (mode_chk && is_bpsk !== exp_mode) mode_bad++;
    tick();
    sym_valid = 1'b0;
    BD_flag   = 1'b0;
  endtask

  task automatic set_pl(input logic [63:0] v, input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(v[n-1-i]);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(1'($urandom));
  endtask

  // Reference: header fields decide drop/error/done; payload bits chunked into 8-bit words, MSB first.
  task automatic send_pkt(input logic sg, input logic [7:0] mcs, input logic [15:0] len,
                          input logic [7:0] sig, input int abort_after);
    logic [31:0] hdr;
    logic [7:0]  w;
    bit          bp, ok, good;
    int          nsym, nsend, e0, d0;
    hdr  = {mcs, len, sig};
    bp   = (mcs == 8'h01);
    ok   = bp || (mcs == 8'h02);
    good = ok && (sig == SIG);
    nsym = bp ? int'(len) : (int'(len) + 1) / 2;
    e0   = n_hdr_err;
    d0   = n_pkt_done;
    BD_flag = 1'b1;
    BD_sgn  = sg;
    tick();
    BD_flag  = 1'b0;
    noise    = 1'b1;
    mode_chk = 1'b1;
    exp_mode = 1'b1;
    mode_bad = 0;
    for (int i = 0; i < 32; i++) send_sym(hdr[31-i] ^ sg, 2'($urandom));
    if (ok && !good) begin
      for (int i = 0; i < nsym; i++) send_sym(1'($urandom), 2'($urandom));
    end else if (good && len != 16'd0) begin
      exp_mode = bp;
      nsend = (abort_after >= 0) ? abort_after : nsym;
      for (int i = 0; i < nsend; i++) begin
        if (bp) send_sym(pl[i] ^ sg, 2'($urandom));
        else send_sym(1'($urandom), {pl[2*i] ^ sg, ((2*i+1 < int'(len)) ? pl[2*i+1] : 1'($urandom)) ^ sg});
      end
      if (abort_after < 0) begin
        for (int i = 0; i < int'(len); i += 8) begin
          w = '0;
          for (int j = 0; j < 8; j++) if (i + j < int'(len)) w[7-j] = pl[i+j];
          exp_q.push_back({(i + 8 >= int'(len)), bp, w});
        end
      end
    end
    noise = 1'b0;
    check("is_bpsk_during_pkt", 32'(mode_bad), 32'd0);
    mode_chk = 1'b0;
    if (abort_after < 0) begin
      repeat (3) tick();
      check("hdr_err_pulses", 32'(n_hdr_err - e0), 32'(!good));
      check("pkt_done_pulses", 32'(n_pkt_done - d0), 32'(good));
      check("is_bpsk_after_pkt", 32'(is_bpsk), 32'd1);
    end
  endtask

  task automatic drain_and_compare();
    logic [9:0] g, e;
    repeat (16) tick();
    check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("word", 32'(g), 32'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int o0;
    logic [7:0] mcs, sig;
    logic [15:0] len;
    int r;

    repeat (3) tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_is_bpsk", 32'(is_bpsk), 32'd1);
    check("rst_pulses", 32'({hdr_err, ovf, pkt_done, m_axis_tlast, m_axis_tuser}), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    rst_n = 1'b1;
    tick();

    set_pl(64'hC35A, 16);
    send_pkt(1'b0, 8'h01, 16'd16, SIG, -1);
    drain_and_compare();

    set_pl(64'b10110100111, 11);
    send_pkt(1'b1, 8'h02, 16'd11, SIG, -1);
    drain_and_compare();

    rand_pl(24);
    send_pkt(1'b0, 8'h01, 16'd24, 8'h00, -1);
    rand_pl(20);
    send_pkt(1'b1, 8'h02, 16'd20, SIG, -1);
    drain_and_compare();

    send_pkt(1'b0, 8'h03, 16'd16, SIG, -1);
    send_pkt(1'b0, 8'h01, 16'd0, SIG, -1);
    rand_pl(9);
    send_pkt(1'b1, 8'h01, 16'd9, SIG, -1);
    drain_and_compare();

    ready_mode = 0;
    o0 = n_ovf;
    rand_pl(40);
    send_pkt(1'b0, 8'h01, 16'd40, SIG, -1);
    repeat (4) tick();
    check("t5_ovf_pulses", 32'(n_ovf - o0), 32'd1);
    check("t5_tvalid", 32'(m_axis_tvalid), 32'd1);
    void'(exp_q.pop_back());
    ready_mode = 2;
    drain_and_compare();

    ready_mode = 0;
    rand_pl(40);
    send_pkt(1'b1, 8'h02, 16'd40, SIG, 14);
    check("t6_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t6_pre_is_bpsk", 32'(is_bpsk), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_is_bpsk", 32'(is_bpsk), 32'd1);
    check("t6_outs", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser, hdr_err, ovf, pkt_done}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    ready_mode = 2;
    tick();
    rand_pl(13);
    send_pkt(1'b0, 8'h02, 16'd13, SIG, -1);
    drain_and_compare();

    o0 = n_ovf;
    for (int k = 0; k < 40; k++) begin
      r   = $urandom % 10;
      mcs = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : (r == 8) ? 8'h03 : 8'h00;
      len = (($urandom % 5) == 0) ? 16'd0 : 16'($urandom_range(1, 50));
      sig = (($urandom % 6) == 0) ? (SIG ^ 8'($urandom_range(1, 255))) : SIG;
      rand_pl(int'(len));
      send_pkt(1'($urandom), mcs, len, sig, -1);
      if ((k % 3) == 2) drain_and_compare();
    end
    drain_and_compare();
    check("random_no_ovf", 32'(n_ovf - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
